// File: rtl/muon_buf_scheduler.sv
// Ring-buffer controller for the muon buffer memory: hands buffers to the writer in order,
// accepts in-order releases from the processor, and tracks fill state, errors and dropped triggers.
module muon_buf_scheduler #(
  parameter int unsigned NBUF       = 4,
  parameter int unsigned NBUF_WIDTH = 2,
  parameter int unsigned WC_WIDTH   = 12,
  parameter int unsigned DROP_WIDTH = 16
) (
  input  logic                  CLK120,
  input  logic                  RESET_N,
  input  logic                  WR_DONE,
  input  logic [WC_WIDTH-1:0]   WR_WORDS,
  input  logic                  TRIG_REQ,
  input  logic                  REL_STROBE,
  input  logic [NBUF_WIDTH-1:0] REL_BUF,
  input  logic                  ERR_CLR,
  output logic                  WR_ENABLE,
  output logic [NBUF_WIDTH-1:0] WR_BUF,
  output logic [NBUF_WIDTH-1:0] RD_BUF,
  output logic [WC_WIDTH-1:0]   RD_WORDS,
  output logic [NBUF-1:0]       FULL_FLAGS,
  output logic [NBUF_WIDTH:0]   NUM_FULL,
  output logic                  INTR,
  output logic                  REL_ERR,
  output logic                  OVR_ERR,
  output logic [DROP_WIDTH-1:0] DROP_CTR,
  output logic [31:0]           STATUS
);

  localparam int unsigned NfWidth = NBUF_WIDTH + 1;
  localparam logic [NBUF_WIDTH:0] NumBuf = NfWidth'(NBUF);

  typedef enum logic [0:0] {StWriting, StStalled} wr_state_e;

  wr_state_e             state_q, state_d;
  logic [NBUF_WIDTH-1:0] wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d;
  logic [NBUF-1:0]       full_q, full_d;
  logic [NBUF_WIDTH:0]   num_full_q, num_full_d;
  logic                  intr_q, intr_d;
  logic                  rel_err_q, rel_err_d;
  logic                  ovr_err_q, ovr_err_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;
  logic [WC_WIDTH-1:0]   words_q [NBUF];
  logic [WC_WIDTH-1:0]   words_d [NBUF];
  logic [WC_WIDTH-1:0]   rd_words_q;
  logic [31:0]           status_q, status_d;

  logic wr_en;
  logic wr_accept;
  logic rel_valid;

  assign wr_en     = (state_q == StWriting);
  assign wr_accept = WR_DONE && wr_en;
  assign rel_valid = REL_STROBE && (REL_BUF == rd_buf_q) && full_q[rd_buf_q];

  always_comb begin
    wr_buf_d   = wr_buf_q;
    rd_buf_d   = rd_buf_q;
    full_d     = full_q;
    num_full_d = num_full_q;
    intr_d     = intr_q;
    rel_err_d  = rel_err_q;
    ovr_err_d  = ovr_err_q;
    drop_d     = drop_q;
    words_d    = words_q;

    // A write can never land on the buffer being released: equal pointers with a
    // free slot means the ring is empty, so no release can be valid.
    if (wr_accept) begin
      full_d[wr_buf_q]  = 1'b1;
      words_d[wr_buf_q] = WR_WORDS;
      wr_buf_d          = wr_buf_q + NBUF_WIDTH'(1);
    end
    if (rel_valid) begin
      full_d[rd_buf_q] = 1'b0;
      rd_buf_d         = rd_buf_q + NBUF_WIDTH'(1);
    end

    case ({wr_accept, rel_valid})
      2'b10:   num_full_d = num_full_q + NfWidth'(1);
      2'b01:   num_full_d = num_full_q - NfWidth'(1);
      default: ;
    endcase

    if (wr_accept) begin
      intr_d = 1'b1;
    end else if (rel_valid && (num_full_d == '0)) begin
      intr_d = 1'b0;
    end

    if (REL_STROBE && !rel_valid) begin
      rel_err_d = 1'b1;
    end else if (ERR_CLR) begin
      rel_err_d = 1'b0;
    end

    if (WR_DONE && !wr_en) begin
      ovr_err_d = 1'b1;
    end else if (ERR_CLR) begin
      ovr_err_d = 1'b0;
    end

    if (TRIG_REQ && !wr_en && (drop_q != '1)) begin
      drop_d = drop_q + DROP_WIDTH'(1);
    end

    state_d = (num_full_d == NumBuf) ? StStalled : StWriting;

    status_d                       = '0;
    status_d[NBUF_WIDTH-1:0]       = wr_buf_d;
    status_d[4 +: NBUF_WIDTH]      = rd_buf_d;
    status_d[8 +: NBUF]            = full_d;
    status_d[12]                   = intr_d;
    status_d[13]                   = rel_err_d;
    status_d[14]                   = ovr_err_d;
    status_d[16 +: NfWidth]        = num_full_d;
    status_d[31:24]                = 8'(drop_d);
  end

  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= StWriting;
      wr_buf_q   <= '0;
      rd_buf_q   <= '0;
      full_q     <= '0;
      num_full_q <= '0;
      intr_q     <= 1'b0;
      rel_err_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
      drop_q     <= '0;
      rd_words_q <= '0;
      status_q   <= '0;
      for (int i = 0; i < int'(NBUF); i++) begin
        words_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_buf_q   <= wr_buf_d;
      rd_buf_q   <= rd_buf_d;
      full_q     <= full_d;
      num_full_q <= num_full_d;
      intr_q     <= intr_d;
      rel_err_q  <= rel_err_d;
      ovr_err_q  <= ovr_err_d;
      drop_q     <= drop_d;
      rd_words_q <= words_q[rd_buf_q];
      status_q   <= status_d;
      words_q    <= words_d;
    end
  end

  assign WR_ENABLE  = wr_en;
  assign WR_BUF     = wr_buf_q;
  assign RD_BUF     = rd_buf_q;
  assign RD_WORDS   = rd_words_q;
  assign FULL_FLAGS = full_q;
  assign NUM_FULL   = num_full_q;
  assign INTR       = intr_q;
  assign REL_ERR    = rel_err_q;
  assign OVR_ERR    = ovr_err_q;
  assign DROP_CTR   = drop_q;
  assign STATUS     = status_q;

endmodule

// File: tb/tb_muon_buf_scheduler.sv
// Self-checking bench for muon_buf_scheduler: expected snapshots are queued as stimulus is
// driven and popped once the DUT has had time to respond.
module tb_muon_buf_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_done;
  logic [11:0] wr_words;
  logic        trig_req;
  logic        rel_strobe;
  logic [1:0]  rel_buf;
  logic        err_clr;

  logic        wr_enable, intr, rel_err, ovr_err;
  logic [1:0]  wr_buf, rd_buf;
  logic [11:0] rd_words;
  logic [3:0]  full_flags;
  logic [2:0]  num_full;
  logic [15:0] drop_ctr;
  logic [31:0] status;

  logic        s_wr_enable, s_intr, s_rel_err, s_ovr_err;
  logic [1:0]  s_wr_buf, s_rd_buf;
  logic [11:0] s_rd_words;
  logic [3:0]  s_full_flags;
  logic [2:0]  s_num_full;
  logic [3:0]  s_drop_ctr;
  logic [31:0] s_status;

  always #5 clk = ~clk;

  muon_buf_scheduler dut (
    .CLK120(clk), .RESET_N(rst_n), .WR_DONE(wr_done), .WR_WORDS(wr_words),
    .TRIG_REQ(trig_req), .REL_STROBE(rel_strobe), .REL_BUF(rel_buf), .ERR_CLR(err_clr),
    .WR_ENABLE(wr_enable), .WR_BUF(wr_buf), .RD_BUF(rd_buf), .RD_WORDS(rd_words),
    .FULL_FLAGS(full_flags), .NUM_FULL(num_full), .INTR(intr), .REL_ERR(rel_err),
    .OVR_ERR(ovr_err), .DROP_CTR(drop_ctr), .STATUS(status)
  );

  // Narrow drop counter so saturation is reachable in a handful of triggers.
  muon_buf_scheduler #(.DROP_WIDTH(4)) dut_sat (
    .CLK120(clk), .RESET_N(rst_n), .WR_DONE(wr_done), .WR_WORDS(wr_words),
    .TRIG_REQ(trig_req), .REL_STROBE(rel_strobe), .REL_BUF(rel_buf), .ERR_CLR(err_clr),
    .WR_ENABLE(s_wr_enable), .WR_BUF(s_wr_buf), .RD_BUF(s_rd_buf), .RD_WORDS(s_rd_words),
    .FULL_FLAGS(s_full_flags), .NUM_FULL(s_num_full), .INTR(s_intr), .REL_ERR(s_rel_err),
    .OVR_ERR(s_ovr_err), .DROP_CTR(s_drop_ctr), .STATUS(s_status)
  );

  typedef struct packed {
    logic [1:0]  wr_buf;
    logic [1:0]  rd_buf;
    logic [3:0]  full;
    logic [2:0]  num_full;
    logic        intr;
    logic        rel_err;
    logic        ovr_err;
    logic        wr_en;
    logic [15:0] drop;
    logic [11:0] rd_words;
  } snap_t;

  snap_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  function automatic snap_t mk(int wr, int rd, int full, int num, int irq, int rerr, int oerr,
                               int en, int drop, int words);
    snap_t s;
    s.wr_buf   = 2'(wr);
    s.rd_buf   = 2'(rd);
    s.full     = 4'(full);
    s.num_full = 3'(num);
    s.intr     = 1'(irq);
    s.rel_err  = 1'(rerr);
    s.ovr_err  = 1'(oerr);
    s.wr_en    = 1'(en);
    s.drop     = 16'(drop);
    s.rd_words = 12'(words);
    return s;
  endfunction

  function automatic snap_t observe();
    snap_t s;
    s.wr_buf   = wr_buf;
    s.rd_buf   = rd_buf;
    s.full     = full_flags;
    s.num_full = num_full;
    s.intr     = intr;
    s.rel_err  = rel_err;
    s.ovr_err  = ovr_err;
    s.wr_en    = wr_enable;
    s.drop     = drop_ctr;
    s.rd_words = rd_words;
    return s;
  endfunction

  function automatic logic [31:0] status_of(snap_t e);
    logic [31:0] s;
    s        = '0;
    s[1:0]   = e.wr_buf;
    s[5:4]   = e.rd_buf;
    s[11:8]  = e.full;
    s[12]    = e.intr;
    s[13]    = e.rel_err;
    s[14]    = e.ovr_err;
    s[18:16] = e.num_full;
    s[31:24] = e.drop[7:0];
    return s;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic apply_reset();
    wr_done = 0; wr_words = '0; trig_req = 0; rel_strobe = 0; rel_buf = '0; err_clr = 0;
    rst_n = 0;
    idle(2);
    rst_n = 1;
    idle(1);
  endtask

  task automatic done(int w);
    wr_done = 1; wr_words = 12'(w);
    cyc();
    wr_done = 0;
  endtask

  task automatic trig();
    trig_req = 1;
    cyc();
    trig_req = 0;
  endtask

  task automatic rel(int b);
    rel_strobe = 1; rel_buf = 2'(b);
    cyc();
    rel_strobe = 0;
  endtask

  task automatic both(int w, int b);
    wr_done = 1; wr_words = 12'(w); rel_strobe = 1; rel_buf = 2'(b);
    cyc();
    wr_done = 0; rel_strobe = 0;
  endtask

  task automatic test_reset();
    snap_t e, o;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    apply_reset();
    e = exp_q.pop_front(); o = observe(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL reset: got %h want %h", o, e); end
    vectors++;
    if (status !== status_of(e)) begin
      miscompares++; $display("FAIL reset_status: got %h want %h", status, status_of(e));
    end
  endtask

  task automatic test_fill();
    snap_t e, o;
    apply_reset();
    exp_q.push_back(mk(3, 0, 4'b0111, 3, 1, 0, 0, 1, 0, 100));
    done(100);
    vectors++;
    if (num_full !== 3'd1 || wr_buf !== 2'd1 || intr !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_latency: got num=%0d wr=%0d intr=%0b want 1 1 1", num_full, wr_buf, intr);
    end
    done(200);
    done(300);
    idle(2);
    e = exp_q.pop_front(); o = observe(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL fill: got %h want %h", o, e); end
    vectors++;
    if (status !== status_of(e)) begin
      miscompares++; $display("FAIL fill_status: got %h want %h", status, status_of(e));
    end
  endtask

  task automatic test_stall();
    snap_t e, o;
    apply_reset();
    exp_q.push_back(mk(0, 0, 4'b1111, 4, 1, 0, 1, 0, 5, 1));
    done(1);
    done(2);
    trig();
    done(3);
    done(4);
    for (int i = 0; i < 5; i++) trig();
    done(9);
    idle(2);
    e = exp_q.pop_front(); o = observe(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL stall: got %h want %h", o, e); end
    vectors++;
    if (status !== status_of(e)) begin
      miscompares++; $display("FAIL stall_status: got %h want %h", status, status_of(e));
    end
  endtask

  task automatic test_release();
    snap_t e, o;
    apply_reset();
    done(10);
    done(20);
    exp_q.push_back(mk(2, 0, 4'b0011, 2, 1, 1, 0, 1, 0, 10));
    rel(1);
    idle(2);
    e = exp_q.pop_front(); o = observe(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL rel_wrong_buf: got %h want %h", o, e); end

    exp_q.push_back(mk(2, 1, 4'b0010, 1, 1, 1, 0, 1, 0, 20));
    rel(0);
    idle(2);
    e = exp_q.pop_front(); o = observe(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL rel_valid: got %h want %h", o, e); end

    // A bad release and ERR_CLR together: the set must win.
    exp_q.push_back(mk(2, 1, 4'b0010, 1, 1, 1, 0, 1, 0, 20));
    rel_strobe = 1; rel_buf = 2'd3; err_clr = 1;
    cyc();
    rel_strobe = 0; err_clr = 0;
    e = exp_q.pop_front(); o = observe(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL rel_set_vs_clr: got %h want %h", o, e); end

    exp_q.push_back(mk(2, 1, 4'b0010, 1, 1, 0, 0, 1, 0, 20));
    err_clr = 1;
    cyc();
    err_clr = 0;
    e = exp_q.pop_front(); o = observe(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL err_clr: got %h want %h", o, e); end
  endtask

  // Continues from test_release: buffer 1 full, WR_BUF=2, RD_BUF=1.
  task automatic test_simultaneous();
    snap_t e, o;
    exp_q.push_back(mk(3, 2, 4'b0100, 1, 1, 0, 0, 1, 0, 30));
    both(30, 1);
    idle(2);
    e = exp_q.pop_front(); o = observe(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL simul: got %h want %h", o, e); end

    exp_q.push_back(mk(3, 3, 4'b0000, 0, 0, 0, 0, 1, 0, 0));
    rel(2);
    idle(2);
    e = exp_q.pop_front(); o = observe(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL last_release: got %h want %h", o, e); end

    exp_q.push_back(mk(3, 3, 4'b0000, 0, 0, 1, 0, 1, 0, 0));
    rel(3);
    e = exp_q.pop_front(); o = observe(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL rel_empty: got %h want %h", o, e); end
  endtask

  task automatic test_stall_release();
    snap_t e, o;
    apply_reset();
    done(5); done(6); done(7); done(8);
    exp_q.push_back(mk(0, 1, 4'b1110, 3, 1, 0, 1, 1, 0, 6));
    both(99, 0);
    vectors++;
    if (wr_enable !== 1'b1) begin
      miscompares++; $display("FAIL stall_rel_wr_en: got %0b want 1", wr_enable);
    end
    idle(2);
    e = exp_q.pop_front(); o = observe(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL stall_rel: got %h want %h", o, e); end

    exp_q.push_back(mk(1, 1, 4'b1111, 4, 1, 0, 1, 0, 0, 6));
    done(50);
    idle(2);
    e = exp_q.pop_front(); o = observe(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL stall_refill: got %h want %h", o, e); end
  endtask

  task automatic test_wrap();
    snap_t e, o;
    apply_reset();
    exp_q.push_back(mk(2, 2, 4'b0000, 0, 0, 0, 0, 1, 0, 7));
    for (int i = 0; i < 10; i++) begin
      done(i + 1);
      rel(i % 4);
    end
    idle(2);
    e = exp_q.pop_front(); o = observe(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL wrap: got %h want %h", o, e); end
    vectors++;
    if (status !== status_of(e)) begin
      miscompares++; $display("FAIL wrap_status: got %h want %h", status, status_of(e));
    end
  endtask

  task automatic test_saturate();
    snap_t e, o;
    apply_reset();
    done(1); done(2); done(3); done(4);
    exp_q.push_back(mk(0, 0, 4'b1111, 4, 1, 0, 0, 0, 20, 1));
    for (int i = 0; i < 20; i++) trig();
    idle(1);
    e = exp_q.pop_front(); o = observe(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL drop_count: got %h want %h", o, e); end
    vectors++;
    if (s_drop_ctr !== 4'hF) begin
      miscompares++; $display("FAIL drop_saturate: got %h want f", s_drop_ctr);
    end
    vectors++;
    if (s_status[31:24] !== 8'h0F) begin
      miscompares++; $display("FAIL drop_sat_status: got %h want 0f", s_status[31:24]);
    end
  endtask

  task automatic test_midreset();
    snap_t e, o;
    apply_reset();
    done(1); done(2); done(3);
    wr_done = 1; wr_words = 12'd4;
    #2 rst_n = 0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    #1;
    e = exp_q.pop_front(); o = observe(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL async_reset: got %h want %h", o, e); end
    vectors++;
    if (status !== 32'h0) begin
      miscompares++; $display("FAIL async_reset_status: got %h want 0", status);
    end
    wr_done = 0;
    #2 rst_n = 1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    idle(2);
    e = exp_q.pop_front(); o = observe(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL post_reset: got %h want %h", o, e); end
  endtask

  initial begin
    rst_n = 0;
    wr_done = 0; wr_words = '0; trig_req = 0; rel_strobe = 0; rel_buf = '0; err_clr = 0;
    test_reset();
    test_fill();
    test_stall();
    test_release();
    test_simultaneous();
    test_stall_release();
    test_wrap();
    test_saturate();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muon_buf_scheduler.md
Name: muon_buf_scheduler

Overview:
- Ring-buffer controller for the muon buffer memory, which is split into NBUF equal buffers.
- Assigns the buffer the muon writer fills and accepts in-order release requests from the processor.
- Tracks full flags, per-buffer word counts and the muon interrupt. Counts triggers dropped while every buffer is full.
- All NBUF buffers are usable; there is no n-1 limit. Sits between the muon write datapath and the AXI register block. AXI-side signals arrive already synchronized to CLK120.

Parameters:
NBUF, 4, number of buffers; power of 2, 2..4
NBUF_WIDTH, 2, log2(NBUF)
WC_WIDTH, 12, word-count width
DROP_WIDTH, 16, dropped-trigger counter width

Ports:
CLK120  in  1  clock, all logic on rising edge
RESET_N  in  1  reset, asynchronous assert, active-low
WR_DONE  in  1  single-cycle pulse: writer finished the current buffer
WR_WORDS  in  WC_WIDTH  word count of the finished buffer; valid with WR_DONE
TRIG_REQ  in  1  single-cycle pulse: writer wants to start a burst
REL_STROBE  in  1  single-cycle release request from the processor
REL_BUF  in  NBUF_WIDTH  buffer number being released
ERR_CLR  in  1  clears the sticky error flags
WR_ENABLE  out  1  a free buffer is available for writing
WR_BUF  out  NBUF_WIDTH  buffer currently being written
RD_BUF  out  NBUF_WIDTH  oldest full buffer (next to be read)
RD_WORDS  out  WC_WIDTH  word count of RD_BUF
FULL_FLAGS  out  NBUF  one bit per full buffer
NUM_FULL  out  NBUF_WIDTH+1  number of full buffers, 0..NBUF
INTR  out  1  muon interrupt pending
REL_ERR  out  1  sticky: invalid release seen
OVR_ERR  out  1  sticky: WR_DONE arrived while WR_ENABLE=0
DROP_CTR  out  DROP_WIDTH  triggers refused while all buffers full
STATUS  out  32  packed status word

Behaviour:
- Reset (RESET_N=0, asynchronous): all outputs 0 except WR_ENABLE=1; internal word-count array = 0.
- All outputs are registered. Every effect is visible on the cycle after the causing input.
- Writer FSM has two states:
  - WRITING: NUM_FULL<NBUF, WR_ENABLE=1.
  - STALLED: NUM_FULL==NBUF, WR_ENABLE=0.
  - WR_ENABLE is computed from next-state NUM_FULL, so it is always consistent with NUM_FULL.
- Accepted WR_DONE (WR_ENABLE=1 in that cycle):
  - FULL_FLAGS[WR_BUF] <= 1; WORDS[WR_BUF] <= WR_WORDS.
  - WR_BUF <= WR_BUF+1, wrapping modulo NBUF.
  - NUM_FULL <= NUM_FULL+1; INTR <= 1.
- WR_DONE while WR_ENABLE=0: ignored; OVR_ERR <= 1.
- TRIG_REQ while WR_ENABLE=0: DROP_CTR+1, saturating at all-ones. TRIG_REQ while WR_ENABLE=1 has no effect.
- Valid release: REL_STROBE=1 and REL_BUF==RD_BUF and FULL_FLAGS[RD_BUF]=1.
  - FULL_FLAGS[RD_BUF] <= 0; RD_BUF <= RD_BUF+1, wrapping modulo NBUF; NUM_FULL <= NUM_FULL-1.
- Any other REL_STROBE: no state change; REL_ERR <= 1.
- Simultaneous accepted WR_DONE and valid release: both take effect; NUM_FULL unchanged.
- In STALLED, WR_DONE and a valid release in the same cycle: the release is applied and WR_DONE is ignored (OVR_ERR set). The freed buffer is writable from the next cycle.
- INTR is cleared when a valid release takes NUM_FULL from 1 to 0 with no simultaneous accepted WR_DONE. A simultaneous WR_DONE wins and INTR stays 1.
- RD_WORDS <= WORDS[RD_BUF], registered one cycle after RD_BUF or the array changes.
- ERR_CLR clears REL_ERR and OVR_ERR. A set event in the same cycle wins. DROP_CTR is cleared only by reset.
- STATUS fields, all other bits 0:
  - [NBUF_WIDTH-1:0] WR_BUF
  - [4+NBUF_WIDTH-1:4] RD_BUF
  - [8+NBUF-1:8] FULL_FLAGS
  - [12] INTR
  - [13] REL_ERR
  - [14] OVR_ERR
  - [16+NBUF_WIDTH:16] NUM_FULL
  - [31:24] DROP_CTR[7:0]
- Reset mid-operation returns immediately to the reset state. No pending event survives reset.

Test Plan:
- Reset release, then 3 WR_DONE pulses with WR_WORDS=100,200,300 -> WR_BUF=3, FULL_FLAGS=0111, NUM_FULL=3, INTR=1, RD_WORDS=100, WR_ENABLE=1.
- 4 WR_DONE pulses, then 5 TRIG_REQ and 1 extra WR_DONE -> WR_ENABLE=0, NUM_FULL=4, DROP_CTR=5, OVR_ERR=1, FULL_FLAGS=1111.
- Buffers 0,1 full; REL_STROBE with REL_BUF=1 -> REL_ERR=1, no state change. Then REL_BUF=0 -> RD_BUF=1, NUM_FULL=1, RD_WORDS equals buffer 1's count; then ERR_CLR -> REL_ERR=0.
- NUM_FULL=1; valid release and WR_DONE in the same cycle -> NUM_FULL=1, INTR stays 1, WR_BUF and RD_BUF both advance.
- Wrap-around: 10 fill/release pairs -> WR_BUF=RD_BUF=2, INTR=0 after the last release. DROP_CTR forced near saturation stays at 0xFFFF.
- Assert RESET_N=0 mid-burst with NUM_FULL=3 -> all outputs 0 asynchronously, WR_ENABLE=1.
